// File: rtl/uart_rx.sv
// UART receive path: 16x-oversampled deserialiser feeding the RX FIFO push port.
// Frames are 8N1 by default; framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_bit,
    input  logic [DIV_WIDTH-1:0] freq_divider,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e                 state_q;
    logic                   sync1_q, sync2_q;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   tick;
    logic [SC_W-1:0]        sc_q;
    logic [BC_W-1:0]        bc_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q, frame_err_q, overrun_q;
    logic                   rxs;

    assign rxs = sync2_q;

    // The >= compare makes a divider lowered below the current count tick at once instead of wrapping.
    always_comb begin
        tick  = (div_q >= freq_divider);
        div_d = tick ? '0 : div_q + DIV_WIDTH'(1);
    end

    // NOTE: all state is assigned with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            div_q       <= '0;
            state_q     <= IDLE;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx_bit;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        sc_q    <= '0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (sc_q == SC_MID) begin
                            sc_q    <= '0;
                            bc_q    <= '0;
                            state_q <= rxs ? IDLE : DATA;
                        end else begin
                            sc_q <= sc_q + SC_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (sc_q == SC_LAST) begin
                            sc_q    <= '0;
                            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                            bc_q    <= bc_q + BC_W'(1);
                            if (bc_q == BC_LAST) state_q <= STOP;
                        end else begin
                            sc_q <= sc_q + SC_W'(1);
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (sc_q == SC_LAST) begin
                            sc_q <= '0;
                            if (!rxs) begin
                                frame_err_q <= 1'b1;
                                state_q     <= WAIT_HIGH;
                            end else begin
                                if (rx_ready) begin
                                    rx_data_q  <= shift_q;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q  <= 1'b1;
                                end
                                state_q <= IDLE;
                            end
                        end else begin
                            sc_q <= sc_q + SC_W'(1);
                        end
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) state_q <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model (expected pulse queue + last byte)
// compared against the DUT outputs every clock, plus directed literal checks.
`timescale 1ns/1ps
module tb_uart_rx;

    typedef enum int { EV_VALID = 0, EV_OVR = 1, EV_FERR = 2 } ev_e;
    typedef struct {
        ev_e        kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       rx_bit;
    logic [7:0] freq_divider;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0, n_ovr = 0, n_ferr = 0;
    int valid_t[$];
    ev_t exp_q[$];
    logic [7:0] model_last = 8'h00;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_bit       (rx_bit),
        .freq_divider (freq_divider),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int tick_clk();
        return int'(freq_divider) + 1;
    endfunction

    function automatic int bit_clk();
        return tick_clk() * 16;
    endfunction

    task automatic send_head(input logic [7:0] d);
        rx_bit = 1'b0;
        wait_clk(bit_clk());
        for (int i = 0; i < 8; i++) begin
            rx_bit = d[i];
            wait_clk(bit_clk());
        end
    endtask

    // Expected outcome follows directly from the frame: low stop -> framing error,
    // otherwise push if the FIFO has room, else overrun.
    task automatic send_frame(input logic [7:0] d, input logic rdy, input int stop_low_ticks);
        ev_t e;
        rx_ready = rdy;
        e.data   = d;
        if (stop_low_ticks > 0) e.kind = EV_FERR;
        else if (rdy)           e.kind = EV_VALID;
        else                    e.kind = EV_OVR;
        exp_q.push_back(e);
        send_head(d);
        if (stop_low_ticks > 0) begin
            rx_bit = 1'b0;
            wait_clk(stop_low_ticks * tick_clk());
        end
        rx_bit = 1'b1;
        wait_clk(bit_clk());
    endtask

    task automatic glitch(input int low_ticks);
        rx_bit = 1'b0;
        wait_clk(low_ticks * tick_clk());
        rx_bit = 1'b1;
        wait_clk(16 * tick_clk());
    endtask

    // Compare process: pulses are matched in order against the expected queue,
    // and rx_data must always equal the last byte the model accepted.
    initial begin : cmp
        int   npulse;
        ev_t  e;
        ev_e  got;
        logic busy_pend;
        logic busy_exp;
        busy_pend = 1'b0;
        busy_exp  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                model_last = 8'h00;
                busy_pend  = 1'b0;
            end else begin
                if (busy_pend) begin
                    check("busy_after_pulse", 32'(busy), 32'(busy_exp));
                    busy_pend = 1'b0;
                end
                npulse = int'(rx_valid) + int'(frame_err) + int'(overrun);
                if (npulse != 0) begin
                    check("pulse_exclusive", 32'(npulse), 32'd1);
                    got = rx_valid ? EV_VALID : (overrun ? EV_OVR : EV_FERR);
                    case (got)
                        EV_VALID: begin n_valid++; valid_t.push_back(cyc); end
                        EV_OVR:   n_ovr++;
                        default:  n_ferr++;
                    endcase
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", 32'(npulse), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_kind", 32'(got), 32'(e.kind));
                        if (e.kind == EV_VALID) model_last = e.data;
                    end
                    busy_pend = 1'b1;
                    busy_exp  = (got == EV_FERR);
                end
                check("rx_data", 32'(rx_data), 32'(model_last));
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int v0, o0, f0, d;
        reset        = 1'b0;
        rx_bit       = 1'b1;
        rx_ready     = 1'b1;
        freq_divider = 8'd0;

        wait_clk(3);
        check("rst_rx_data",   32'(rx_data),   32'h00);
        check("rst_rx_valid",  32'(rx_valid),  32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        @(posedge clk); #2 reset = 1'b1;
        wait_clk(20);

        // 0xA5 at 16 clk per bit
        v0 = n_valid; o0 = n_ovr; f0 = n_ferr;
        send_frame(8'hA5, 1'b1, 0);
        wait_clk(16);
        check("a5_valid_count", 32'(n_valid - v0), 32'd1);
        check("a5_no_err",      32'((n_ovr - o0) + (n_ferr - f0)), 32'd0);
        check("a5_data",        32'(rx_data), 32'hA5);

        // Short low glitch is a false start
        v0 = n_valid; o0 = n_ovr; f0 = n_ferr;
        rx_bit = 1'b0;
        wait_clk(4 * tick_clk());
        check("glitch_busy_high", 32'(busy), 32'd1);
        rx_bit = 1'b1;
        wait_clk(16 * tick_clk());
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_pulse", 32'((n_valid - v0) + (n_ovr - o0) + (n_ferr - f0)), 32'd0);
        wait_clk(bit_clk());

        // 0x3C with stop bit stuck low for 40 ticks
        v0 = n_valid; f0 = n_ferr;
        begin
            ev_t e;
            e.kind = EV_FERR; e.data = 8'h3C;
            exp_q.push_back(e);
        end
        send_head(8'h3C);
        rx_bit = 1'b0;
        wait_clk(30 * tick_clk());
        check("ferr_count",      32'(n_ferr - f0), 32'd1);
        check("ferr_busy_held",  32'(busy), 32'd1);
        wait_clk(10 * tick_clk());
        check("ferr_busy_still", 32'(busy), 32'd1);
        rx_bit = 1'b1;
        wait_clk(4);
        check("ferr_busy_release", 32'(busy), 32'd0);
        check("ferr_no_valid",   32'(n_valid - v0), 32'd0);
        check("ferr_data_kept",  32'(rx_data), 32'hA5);
        wait_clk(bit_clk());

        // Overrun on 0x55, then 0x66 accepted
        v0 = n_valid; o0 = n_ovr;
        send_frame(8'h55, 1'b0, 0);
        wait_clk(16);
        check("ovr_count",      32'(n_ovr - o0), 32'd1);
        check("ovr_no_valid",   32'(n_valid - v0), 32'd0);
        check("ovr_data_kept",  32'(rx_data), 32'hA5);
        send_frame(8'h66, 1'b1, 0);
        wait_clk(16);
        check("after_ovr_data", 32'(rx_data), 32'h66);

        // Reset mid-byte, then 0x81
        v0 = n_valid; o0 = n_ovr; f0 = n_ferr;
        rx_bit = 1'b0;
        wait_clk(bit_clk());
        for (int i = 0; i < 4; i++) begin
            rx_bit = 1'b1 & (i == 0);
            wait_clk(bit_clk());
        end
        #2 reset = 1'b0;
        rx_bit = 1'b1;
        #1;
        check("midrst_rx_data",  32'(rx_data),  32'h00);
        check("midrst_busy",     32'(busy),     32'd0);
        check("midrst_pulses",   32'({rx_valid, frame_err, overrun}), 32'd0);
        wait_clk(2 * bit_clk());
        @(posedge clk); #2 reset = 1'b1;
        wait_clk(20);
        check("midrst_no_pulse", 32'((n_valid - v0) + (n_ovr - o0) + (n_ferr - f0)), 32'd0);
        send_frame(8'h81, 1'b1, 0);
        wait_clk(16);
        check("after_rst_data",  32'(rx_data), 32'h81);

        // Back-to-back 0x00 then 0xFF at 112 clk per bit
        freq_divider = 8'd6;
        wait_clk(bit_clk());
        v0 = valid_t.size();
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        wait_clk(bit_clk());
        check("b2b_count", 32'(valid_t.size() - v0), 32'd2);
        if (valid_t.size() - v0 == 2) begin
            d = valid_t[v0 + 1] - valid_t[v0];
            check("b2b_spacing_1120pm7", 32'(d >= 1113 && d <= 1127), 32'd1);
        end
        check("b2b_last_data", 32'(rx_data), 32'hFF);

        // Randomised frames, glitches, overruns and framing errors
        for (int n = 0; n < 40; n++) begin
            freq_divider = 8'($urandom_range(0, 2));
            wait_clk($urandom_range(0, 2) * bit_clk());
            if ($urandom_range(0, 7) == 0) begin
                glitch($urandom_range(1, 5));
            end else begin
                send_frame(8'($urandom),
                           ($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 40)) : 0);
            end
        end
        rx_bit = 1'b1;
        wait_clk(2 * bit_clk());
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_idle",    32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART: deserialises the asynchronous rx_bit line into bytes and pushes them into the RX FIFO read by the Wishbone RX_DATA register.
- Uses 16x oversampling from the same clk/freq_divider scheme as the TX path, so TX and RX share one programmed divider.
- Sits between the pad and the RX FIFO push port.
- Reports framing errors and overruns as single-cycle pulses for status logic.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first, no parity
OVERSAMPLE, 16, sample ticks per bit period
DIV_WIDTH, 8, width of freq_divider

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_bit  input  1  serial line, asynchronous to clk, idle high
freq_divider  input  DIV_WIDTH  tick period minus one, in clk cycles
rx_ready  input  1  FIFO can accept a byte (not full)
rx_data  output  DATA_BITS  last correctly received byte
rx_valid  output  1  one-cycle push strobe to the FIFO
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte dropped because rx_ready=0
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset=0, async):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - State IDLE; all counters 0.
  - Synchroniser flops preset to 1.
- Synchroniser: 2-flop chain on rx_bit; all logic uses the synchronised value rxs. This adds 2 clk of latency.
- Tick generator:
  - Free-running div counter.
  - When div counter >= freq_divider: tick=1 for one clk and the counter clears; otherwise it increments.
  - Tick period is freq_divider+1 clk. freq_divider=0 gives a tick every clk.
  - A live divider change takes effect on the next compare; the >= compare prevents a 2^DIV_WIDTH wrap.
- FSM, sample counter sc (4 bits), bit counter bc:
  - IDLE: if rxs=0, go to START with sc=0. Detection is evaluated on every clk, not only on ticks.
  - START:
    - On each tick, sc++.
    - At the tick where sc reaches OVERSAMPLE/2-1 (8th tick), sample rxs.
    - If rxs=0: go to DATA with sc=0, bc=0.
    - If rxs=1: false start, return to IDLE with no output.
  - DATA:
    - On each tick, sc++.
    - When sc wraps from OVERSAMPLE-1 to 0 (mid-bit), shift rxs into the shift register at the MSB end (LSB-first assembly) and increment bc.
    - After DATA_BITS samples, go to STOP.
  - STOP: at the next mid-bit tick, sample rxs.
    - rxs=1 and rx_ready=1: rx_data<=shift, rx_valid=1 for exactly one clk; go to IDLE.
    - rxs=1 and rx_ready=0: overrun=1 for one clk; rx_data unchanged; go to IDLE.
    - rxs=0: frame_err=1 for one clk; no push; rx_data unchanged; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1 (break or stuck-low line), then go to IDLE. No new start is detected while in this state.
- rx_data updates in the same clk that rx_valid asserts. rx_valid, frame_err and overrun are mutually exclusive.
- Returning to IDLE from the STOP mid-bit sample allows a back-to-back start edge half a bit later.
- Reset mid-frame aborts the frame immediately; no pulse is emitted and the partial byte is discarded.
- Tick phase is not re-aligned to the start edge; the sampling point jitters by up to 1 tick (1/16 bit). This is accepted.

Test Plan:
- freq_divider=0 (bit = 16 clk): drive 0xA5 8N1 -> exactly one rx_valid pulse, rx_data=0xA5, frame_err=0, overrun=0, busy low within 1 clk after the pulse.
- rx_bit low for 4 ticks then high (glitch) -> FSM returns to IDLE at the 8th tick, no rx_valid/frame_err/overrun pulse, busy deasserts.
- Drive 0x3C with stop bit held low for 40 ticks -> one frame_err pulse, no rx_valid, busy stays high until the line returns high, rx_data keeps its previous value.
- rx_ready=0 during the stop bit of 0x55 -> one overrun pulse, no rx_valid, rx_data unchanged. Next byte 0x66 with rx_ready=1 -> rx_data=0x66.
- reset=0 pulsed mid-byte (after bit 3) -> all outputs 0 asynchronously, no pulse. After release, byte 0x81 is received as 0x81.
- freq_divider=6: back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses 10 bit periods (1120 clk, ±7) apart, data 0x00 then 0xFF.
